// File: rtl/alu_ctrl_pkg.sv
// Shared state encoding for the ALU front-panel entry sequencer.
package alu_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

endpackage

// File: rtl/alu_entry_sequencer_if.sv
// Panel/ALU signal bundle between the entry sequencer and its surroundings.
interface alu_entry_sequencer_if
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned OP_WIDTH = 3
);
    logic                enter_rise;
    logic                clear_rise;
    logic [WIDTH-1:0]    switches;
    logic [WIDTH-1:0]    alu_result;
    logic [WIDTH-1:0]    operand_a;
    logic [WIDTH-1:0]    operand_b;
    logic [OP_WIDTH-1:0] opcode;
    logic                alu_start;
    logic [WIDTH-1:0]    result;
    logic                done;
    logic                err;
    logic [STATE_W-1:0]  state_led;

    modport master (
        input  enter_rise, clear_rise, switches, alu_result,
        output operand_a, operand_b, opcode, alu_start, result, done, err, state_led
    );

    modport slave (
        output enter_rise, clear_rise, switches, alu_result,
        input  operand_a, operand_b, opcode, alu_start, result, done, err, state_led
    );
endinterface

// File: rtl/cycle_timer.sv
// Saturating up-counter that flags once it has counted MAX enabled cycles.
module cycle_timer #(
    parameter int unsigned MAX = 1
) (
    input  logic clock,
    input  logic rstsync,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (rstsync || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CMAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CMAX);
endmodule

// File: rtl/alu_entry_sequencer.sv
// Front-panel controller: steps through A/B/opcode entry, fires the ALU, holds its result.
module alu_entry_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned OP_WIDTH       = 3,
    parameter int unsigned ALU_LATENCY    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 rstsync,
    alu_entry_sequencer_if.master bus
);
    state_t state_q, state_n;
    logic   ld_a, ld_b, ld_op, cap, start_n, to_err;
    logic   lat_done, idle_expired, in_entry;

    logic [WIDTH-1:0]    operand_a_q, operand_b_q, result_q;
    logic [OP_WIDTH-1:0] opcode_q;
    logic                alu_start_q, err_q;

    assign in_entry = (state_q == S_B) || (state_q == S_OP);

    // Latency counter is zero on the first S_EXEC cycle because it is held clear outside S_EXEC.
    cycle_timer #(.MAX(ALU_LATENCY)) u_lat (
        .clock   (clock),
        .rstsync (rstsync),
        .clr     (state_q != S_EXEC),
        .en      (1'b1),
        .expired (lat_done)
    );

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_idle
            cycle_timer #(.MAX(TIMEOUT_CYCLES)) u_idle (
                .clock   (clock),
                .rstsync (rstsync),
                .clr     (!in_entry || bus.enter_rise),
                .en      (1'b1),
                .expired (idle_expired)
            );
        end else begin : g_no_idle
            assign idle_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (rstsync) state_q <= S_A;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        cap     = 1'b0;
        start_n = 1'b0;
        to_err  = 1'b0;
        if (bus.clear_rise) begin
            state_n = S_A;
        end else begin
            case (state_q)
                S_A: if (bus.enter_rise) begin
                    ld_a    = 1'b1;
                    state_n = S_B;
                end
                S_B: if (bus.enter_rise) begin
                    ld_b    = 1'b1;
                    state_n = S_OP;
                end else if (idle_expired) begin
                    to_err  = 1'b1;
                    state_n = S_A;
                end
                S_OP: if (bus.enter_rise) begin
                    ld_op   = 1'b1;
                    start_n = 1'b1;
                    state_n = S_EXEC;
                end else if (idle_expired) begin
                    to_err  = 1'b1;
                    state_n = S_A;
                end
                S_EXEC: if (lat_done) begin
                    cap     = 1'b1;
                    state_n = S_SHOW;
                end
                S_SHOW: if (bus.enter_rise) state_n = S_A;
                default: state_n = S_A;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rstsync) begin
            operand_a_q <= '0;
            operand_b_q <= '0;
            opcode_q    <= '0;
            result_q    <= '0;
            alu_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            alu_start_q <= start_n;
            if (bus.clear_rise) begin
                operand_a_q <= '0;
                operand_b_q <= '0;
                opcode_q    <= '0;
                result_q    <= '0;
                err_q       <= 1'b0;
            end else begin
                if (ld_a) begin
                    operand_a_q <= bus.switches;
                    err_q       <= 1'b0;
                end
                if (ld_b)   operand_b_q <= bus.switches;
                if (ld_op)  opcode_q    <= bus.switches[OP_WIDTH-1:0];
                if (cap)    result_q    <= bus.alu_result;
                if (to_err) err_q       <= 1'b1;
            end
        end
    end

    assign bus.operand_a = operand_a_q;
    assign bus.operand_b = operand_b_q;
    assign bus.opcode    = opcode_q;
    assign bus.alu_start = alu_start_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.done      = (state_q == S_SHOW);
    assign bus.state_led = state_q;
endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Directed bench: three sequencer instances (latency 1, 0, 3; the last with a 10-cycle timeout).
module tb_alu_entry_sequencer;
    import alu_ctrl_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      rst, enter, clr;
    logic [N-1:0][7:0] sw, ares;
    logic [N-1:0][7:0] oa, ob, res;
    logic [N-1:0][2:0] op, st;
    logic [N-1:0]      start, done, err;

    int errors = 0;
    int checks = 0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            localparam int unsigned LAT = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
            localparam int unsigned TO  = (gi == 2) ? 10 : 0;
            alu_entry_sequencer_if #(.WIDTH(8), .OP_WIDTH(3)) bus ();
            alu_entry_sequencer #(
                .WIDTH(8), .OP_WIDTH(3), .ALU_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
            ) dut (
                .clock   (clk),
                .rstsync (rst[gi]),
                .bus     (bus.master)
            );
            assign bus.enter_rise = enter[gi];
            assign bus.clear_rise = clr[gi];
            assign bus.switches   = sw[gi];
            assign bus.alu_result = ares[gi];
            assign oa[gi]    = bus.operand_a;
            assign ob[gi]    = bus.operand_b;
            assign op[gi]    = bus.opcode;
            assign start[gi] = bus.alu_start;
            assign res[gi]   = bus.result;
            assign done[gi]  = bus.done;
            assign err[gi]   = bus.err;
            assign st[gi]    = bus.state_led;
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_val(input int i, input logic [7:0] v);
        sw[i]    = v;
        enter[i] = 1'b1;
        step();
        enter[i] = 1'b0;
    endtask

    initial begin
        rst = '1; enter = '0; clr = '0; sw = '0; ares = '0;
        step(2);
        for (int i = 0; i < N; i++) begin
            chk("rst_state", st[i], 0);
            chk("rst_data", {oa[i], ob[i], res[i], 5'(op[i])}, 0);
            chk("rst_flags", {start[i], done[i], err[i]}, 0);
        end
        rst = '0;

        // Basic entry, latency 1
        ares[0] = 8'h17;
        enter_val(0, 8'h12);
        chk("t1_state_b", st[0], 1);
        chk("t1_a", oa[0], 8'h12);
        enter_val(0, 8'h05);
        chk("t1_state_op", st[0], 2);
        chk("t1_b", ob[0], 8'h05);
        enter_val(0, 8'h02);
        chk("t1_state_exec", st[0], 3);
        chk("t1_op", op[0], 2);
        chk("t1_start_T", start[0], 1);
        step();
        chk("t1_start_T1", start[0], 0);
        chk("t1_res_T1", res[0], 0);
        chk("t1_done_T1", done[0], 0);
        step();
        chk("t1_state_show", st[0], 4);
        chk("t1_done", done[0], 1);
        chk("t1_result", res[0], 8'h17);

        // Return from S_SHOW, then a second sequence overwrites result
        enter_val(0, 8'h00);
        chk("t6_state_a", st[0], 0);
        chk("t6_done", done[0], 0);
        chk("t6_res_held", res[0], 8'h17);
        ares[0] = 8'h3C;
        enter_val(0, 8'h30);
        enter_val(0, 8'h0C);
        enter_val(0, 8'hFD);
        chk("t6_op_trunc", op[0], 5);
        step(2);
        chk("t6_done2", done[0], 1);
        chk("t6_result2", res[0], 8'h3C);

        // enter and clear together in S_OP
        enter_val(0, 8'h00);
        enter_val(0, 8'h44);
        enter_val(0, 8'h55);
        chk("t3_state_op", st[0], 2);
        sw[0] = 8'h07; enter[0] = 1'b1; clr[0] = 1'b1;
        step();
        enter[0] = 1'b0; clr[0] = 1'b0;
        chk("t3_state", st[0], 0);
        chk("t3_data", {oa[0], ob[0], res[0], 5'(op[0])}, 0);
        chk("t3_err", err[0], 0);
        step();
        chk("t3_no_start", start[0], 0);

        // Latency 0, enter during S_EXEC dropped
        ares[1] = 8'h5A;
        enter_val(1, 8'h01);
        enter_val(1, 8'h02);
        enter_val(1, 8'h03);
        chk("t2l0_state_exec", st[1], 3);
        chk("t2l0_start", start[1], 1);
        chk("t2l0_res_T", res[1], 0);
        enter_val(1, 8'h00);
        chk("t2l0_state_show", st[1], 4);
        chk("t2l0_result", res[1], 8'h5A);
        chk("t2l0_start_off", start[1], 0);
        step();
        chk("t2l0_enter_dropped", st[1], 4);

        // Latency 3, enter during S_EXEC
        ares[2] = 8'hC3;
        enter_val(2, 8'h0A);
        enter_val(2, 8'h0B);
        enter_val(2, 8'h04);
        chk("t2l3_start_T", start[2], 1);
        step();
        enter_val(2, 8'h00);
        chk("t2l3_start_T2", start[2], 0);
        chk("t2l3_state_T2", st[2], 3);
        step();
        chk("t2l3_state_T3", st[2], 3);
        chk("t2l3_res_T3", res[2], 0);
        step();
        chk("t2l3_state_show", st[2], 4);
        chk("t2l3_result", res[2], 8'hC3);
        chk("t2l3_start_T4", start[2], 0);

        // Entry timeout
        clr[2] = 1'b1; step(); clr[2] = 1'b0;
        chk("t4_cleared_res", res[2], 0);
        enter_val(2, 8'hAA);
        step(5);
        chk("t4_still_b", st[2], 1);
        step(7);
        chk("t4_state_a", st[2], 0);
        chk("t4_err", err[2], 1);
        chk("t4_a_kept", oa[2], 8'hAA);
        enter_val(2, 8'h11);
        chk("t4_err_clr", err[2], 0);
        chk("t4_a_new", oa[2], 8'h11);
        chk("t4_state_b", st[2], 1);

        // Reset during S_EXEC
        enter_val(2, 8'h22);
        enter_val(2, 8'h01);
        chk("t5_start", start[2], 1);
        step();
        rst[2] = 1'b1; step(); rst[2] = 1'b0;
        chk("t5_state", st[2], 0);
        chk("t5_data", {oa[2], ob[2], res[2], 5'(op[2])}, 0);
        chk("t5_flags", {start[2], done[2], err[2]}, 0);
        step(6);
        chk("t5_idle_state", st[2], 0);
        chk("t5_no_capture", res[2], 0);
        ares[2] = 8'h99;
        enter_val(2, 8'h31);
        enter_val(2, 8'h32);
        enter_val(2, 8'h06);
        chk("t5_op", op[2], 6);
        chk("t5_start2", start[2], 1);
        step(3);
        chk("t5_res_pre", res[2], 0);
        step();
        chk("t5_done", done[2], 1);
        chk("t5_result", res[2], 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
